turn_signal_ctrl: RTL and testbench

Upstream controller for the tail-light sequencer FSMs. It synchronizes the raw left, right and hazard switches and resolves them into one lamp mode. It produces the level enables that drive the left and right sequencer FSMs, plus a divided step pulse. Mode changes are deferred to pattern boundaries, so a running light sequence is never cut off mid-pattern.

---
 rtl/turn_pkg.sv | 25 ++
 rtl/turn_signal_ctrl_sync2.sv | 25 ++
 rtl/turn_signal_ctrl.sv | 103 ++++++++++
 tb/tb_turn_signal_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared mode encoding, default timing constants and helpers for the
// turn-signal controller.
package turn_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_LEFT  = 2'd1;
  localparam logic [1:0] MODE_RIGHT = 2'd2;
  localparam logic [1:0] MODE_HAZ   = 2'd3;

  localparam int DEF_TICK_DIV = 4;
  localparam int DEF_SEQ_LEN  = 4;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Hazard wins, and left+right together is treated as hazard.
  function automatic logic [1:0] decode_req(input logic l, input logic r, input logic h);
    if (h || (l && r)) return MODE_HAZ;
    else if (l)        return MODE_LEFT;
    else if (r)        return MODE_RIGHT;
    else               return MODE_IDLE;
  endfunction

endpackage

// File: rtl/turn_signal_ctrl_sync2.sv
// Two-flop synchronizer for one asynchronous switch, cleared by a
// synchronous reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/turn_signal_ctrl.sv
// Resolves synchronized turn/hazard switches into a lamp mode, emits the
// sequencer enables and a divided step pulse; mode changes wait for a pattern end.
module turn_signal_ctrl
  import turn_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SEQ_LEN  = DEF_SEQ_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_sw,
  input  logic       right_sw,
  input  logic       haz_sw,
  output logic       ena_left,
  output logic       ena_right,
  output logic       step,
  output logic [1:0] mode
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam int SW = cnt_width(SEQ_LEN);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEQ_LAST  = SW'(SEQ_LEN - 1);

  logic [2:0] sw_raw;
  logic [2:0] sw_sync;

  assign sw_raw = {haz_sw, right_sw, left_sw};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sw_raw[gi]),
        .q_o (sw_sync[gi])
      );
    end
  endgenerate

  logic [1:0]    mode_q, mode_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] seq_q, seq_d;
  logic          step_q, step_d;
  logic          ena_left_q, ena_left_d;
  logic          ena_right_q, ena_right_d;
  logic [1:0]    req;
  logic          boundary;

  assign req      = decode_req(sw_sync[0], sw_sync[1], sw_sync[2]);
  assign boundary = step_q && (seq_q == SEQ_LAST);

  always_comb begin
    mode_d = mode_q;
    tick_d = tick_q;
    seq_d  = seq_q;
    step_d = 1'b0;
    if (mode_q == MODE_IDLE) begin
      if (req != MODE_IDLE) begin
        mode_d = req;
        tick_d = '0;
        seq_d  = '0;
      end
    end else if (boundary && (req != mode_q)) begin
      // A new request (including IDLE) restarts the pattern from zero.
      mode_d = req;
      tick_d = '0;
      seq_d  = '0;
    end else begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
      step_d = (tick_q == TICK_LAST);
      if (step_q) begin
        seq_d = (seq_q == SEQ_LAST) ? '0 : seq_q + 1'b1;
      end
    end
    ena_left_d  = (mode_d == MODE_LEFT)  || (mode_d == MODE_HAZ);
    ena_right_d = (mode_d == MODE_RIGHT) || (mode_d == MODE_HAZ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_IDLE;
      tick_q      <= '0;
      seq_q       <= '0;
      step_q      <= 1'b0;
      ena_left_q  <= 1'b0;
      ena_right_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      tick_q      <= tick_d;
      seq_q       <= seq_d;
      step_q      <= step_d;
      ena_left_q  <= ena_left_d;
      ena_right_q <= ena_right_d;
    end
  end

  assign mode      = mode_q;
  assign step      = step_q;
  assign ena_left  = ena_left_q;
  assign ena_right = ena_right_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl: a cycle-phase model checked every
// cycle, plus hand-computed latency and step-timing expectations.
module tb_turn_signal_ctrl;

  localparam int TD = 4;
  localparam int SL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left_sw = 1'b0;
  logic       right_sw = 1'b0;
  logic       haz_sw = 1'b0;
  logic       ena_left;
  logic       ena_right;
  logic       step;
  logic [1:0] mode;

  always #5 clk = ~clk;

  turn_signal_ctrl #(.TICK_DIV(TD), .SEQ_LEN(SL)) dut (
    .clk       (clk),
    .rst       (rst),
    .left_sw   (left_sw),
    .right_sw  (right_sw),
    .haz_sw    (haz_sw),
    .ena_left  (ena_left),
    .ena_right (ena_right),
    .step      (step),
    .mode      (mode)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: mode plus c = clock cycles elapsed since the current pattern run began.
  int m_mode = 0;
  int m_c = 0;
  bit m_step = 1'b0;
  int pend1 = 0;
  int pend2 = 0;
  bit m_valid = 1'b0;

  function automatic int req_of(input bit l, input bit r, input bit h);
    if (h || (l && r)) return 3;
    if (l) return 1;
    if (r) return 2;
    return 0;
  endfunction

  initial begin
    bit cur_step;
    bit bnd;
    int req;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_mode = 0; m_c = 0; pend1 = 0; pend2 = 0;
        m_valid = 1'b1;
      end else begin
        cur_step = (m_mode != 0) && (m_c > 0) && (m_c % TD == 0);
        bnd = cur_step && ((m_c / TD) % SL == 0);
        req = pend2;
        if (m_mode == 0) begin
          if (req != 0) begin m_mode = req; m_c = 0; end
        end else if (bnd && req != m_mode) begin
          m_mode = req; m_c = 0;
        end else begin
          m_c++;
        end
        pend2 = pend1;
        pend1 = req_of(left_sw, right_sw, haz_sw);
      end
      m_step = (m_mode != 0) && (m_c > 0) && (m_c % TD == 0);
    end
  end

  initial begin
    bit el;
    bit er;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        el = (m_mode == 1) || (m_mode == 3);
        er = (m_mode == 2) || (m_mode == 3);
        vectors++;
        if (mode !== m_mode[1:0] || step !== m_step || ena_left !== el || ena_right !== er) begin
          miscompares++;
          $display("FAIL cycle %0d outputs: mode/step/ena_l/ena_r = %0d/%b/%b/%b, model %0d/%b/%b/%b",
                   cyc, mode, step, ena_left, ena_right, m_mode, m_step, el, er);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_mode(input string name, input logic [1:0] target, input int maxc, output int n);
    n = 0;
    while (mode !== target && n < maxc) begin
      tick();
      n++;
    end
    check({name, "_reached"}, int'(mode), int'(target));
  endtask

  initial begin
    int n;
    int steps[$];
    int idle_at;
    int haz_at;
    int step_after;
    int el_at;
    int er_at;

    // Reset held with every switch on
    rst = 1'b1; left_sw = 1'b1; right_sw = 1'b1; haz_sw = 1'b1;
    repeat (5) tick();
    check("rst_mode", int'(mode), 0);
    check("rst_step", int'(step), 0);
    rst = 1'b0;
    wait_mode("rst_release", 2'd3, 10, n);
    check("rst_release_latency", n, 3);
    left_sw = 1'b0; right_sw = 1'b0; haz_sw = 1'b0;
    wait_mode("haz_drain", 2'd0, 40, n);
    repeat (2) tick();

    // Left only, then release mid-pattern
    left_sw = 1'b1;
    wait_mode("left", 2'd1, 10, n);
    check("left_latency", n, 3);
    check("left_ena_left", int'(ena_left), 1);
    check("left_ena_right", int'(ena_right), 0);
    idle_at = -1;
    for (int rel = 1; rel <= 22; rel++) begin
      tick();
      if (step === 1'b1) steps.push_back(rel);
      if (mode === 2'd0 && idle_at < 0) idle_at = rel;
      if (rel == 7) left_sw = 1'b0;
    end
    check("left_step_count", steps.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("left_step%0d_cycle", i), (i < steps.size()) ? steps[i] : -1, 4 * (i + 1));
    check("left_release_cycle", idle_at, 17);

    // Right, hazard raised mid-pattern
    right_sw = 1'b1;
    wait_mode("right", 2'd2, 10, n);
    check("right_latency", n, 3);
    haz_at = -1; step_after = -1; el_at = 0; er_at = 0;
    for (int rel = 1; rel <= 24; rel++) begin
      tick();
      if (rel == 5) haz_sw = 1'b1;
      if (mode === 2'd3 && haz_at < 0) begin
        haz_at = rel; el_at = int'(ena_left); er_at = int'(ena_right);
      end
      if (haz_at >= 0 && step === 1'b1 && step_after < 0) step_after = rel;
    end
    check("haz_switch_cycle", haz_at, 17);
    check("haz_switch_ena_left", el_at, 1);
    check("haz_switch_ena_right", er_at, 1);
    check("haz_first_step_cycle", step_after, 21);
    right_sw = 1'b0; haz_sw = 1'b0;
    wait_mode("haz_release", 2'd0, 60, n);
    repeat (2) tick();

    // Left and right together, then mid-pattern reset
    left_sw = 1'b1; right_sw = 1'b1;
    wait_mode("both", 2'd3, 10, n);
    check("both_latency", n, 3);
    check("both_ena_left", int'(ena_left), 1);
    check("both_ena_right", int'(ena_right), 1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("midrst_mode", int'(mode), 0);
    check("midrst_step", int'(step), 0);
    check("midrst_enables", int'({ena_left, ena_right}), 0);
    rst = 1'b0;
    wait_mode("midrst_recover", 2'd3, 10, n);
    check("midrst_recover_latency", n, 3);
    left_sw = 1'b0; right_sw = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
